// File: rtl/led_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : led_seq_pkg                                                 |
// | Brief  : Shared mode and direction encodings for the LED sequencer.  |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
package led_seq_pkg;

    // Pattern modes as presented on the mode input
    localparam logic [1:0] MODE_ROT_L  = 2'd0;
    localparam logic [1:0] MODE_ROT_R  = 2'd1;
    localparam logic [1:0] MODE_BOUNCE = 2'd2;
    localparam logic [1:0] MODE_FILL   = 2'd3;

    // Travel direction of the hot bit in bounce mode
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage : led_seq_pkg
`default_nettype wire

// File: rtl/led_step_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : led_step_timer                                              |
// | Brief  : Step prescaler; fires once every max(period,1) enabled      |
// |          clocks. The >= compare makes a shrinking period take effect |
// |          on the very next enabled clock.                             |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module led_step_timer #(
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    output logic                step
);

    localparam logic [PERIOD_W-1:0] c_ONE = PERIOD_W'(1);

    logic [PERIOD_W-1:0] r_tick_cnt;
    logic [PERIOD_W-1:0] w_eff_period;
    logic                w_due;

    // A zero period behaves like one so the pattern never stalls
    always_comb begin
        w_eff_period = (period == '0) ? c_ONE : period;
        w_due        = (r_tick_cnt >= (w_eff_period - c_ONE));
        step         = enable && w_due && !clear;
    end

    // Tick counter: cleared on reload, frozen while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (clear) begin
            r_tick_cnt <= '0;
        end else if (enable) begin
            if (w_due) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + c_ONE;
            end
        end
    end

endmodule : led_step_timer
`default_nettype wire

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : led_pattern_sequencer                                       |
// | Brief  : Multi-mode LED chaser (rotate left/right, bounce, bar fill) |
// |          with per-step and end-of-sequence sync pulses.              |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic [WIDTH-1:0]    led_out,
    output logic                step_pulse,
    output logic                wrap_pulse
);

    // Every mode starts from bit0 alone
    localparam logic [WIDTH-1:0] c_SEED = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_led;
    logic [1:0]       r_mode;
    logic             r_dir;
    logic             r_step_pulse;
    logic             r_wrap_pulse;

    logic             w_reload;
    logic             w_step;
    logic [WIDTH-1:0] w_next_led;
    logic             w_next_dir;

    // A mode change is treated exactly like an explicit restart
    assign w_reload = restart || (mode != r_mode);

    led_step_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .clear  (w_reload),
        .period (period),
        .step   (w_step)
    );

    // Next pattern and bounce direction for the currently latched mode
    always_comb begin
        w_next_led = r_led;
        w_next_dir = r_dir;
        case (r_mode)
            MODE_ROT_L: begin
                w_next_led = {r_led[WIDTH-2:0], r_led[WIDTH-1]};
            end
            MODE_ROT_R: begin
                w_next_led = {r_led[0], r_led[WIDTH-1:1]};
            end
            MODE_BOUNCE: begin
                // Turn around on arrival at an end so no end bit repeats
                if (r_dir == DIR_UP) begin
                    w_next_led = {r_led[WIDTH-2:0], 1'b0};
                    if (w_next_led[WIDTH-1]) begin
                        w_next_dir = DIR_DOWN;
                    end
                end else begin
                    w_next_led = {1'b0, r_led[WIDTH-1:1]};
                    if (w_next_led[0]) begin
                        w_next_dir = DIR_UP;
                    end
                end
            end
            MODE_FILL: begin
                // Full bar empties to zero, and zero refills to the seed
                w_next_led = (&r_led) ? '0 : {r_led[WIDTH-2:0], 1'b1};
            end
            default: begin
                w_next_led = r_led;
            end
        endcase
    end

    // Pattern, mode, direction and pulse registers; reload beats a step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_led        <= c_SEED;
            r_mode       <= MODE_ROT_L;
            r_dir        <= DIR_UP;
            r_step_pulse <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else if (w_reload) begin
            r_led        <= c_SEED;
            r_mode       <= mode;
            r_dir        <= DIR_UP;
            r_step_pulse <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end else if (w_step) begin
            r_led        <= w_next_led;
            r_dir        <= w_next_dir;
            r_step_pulse <= 1'b1;
            r_wrap_pulse <= (w_next_led == c_SEED);
        end else begin
            r_step_pulse <= 1'b0;
            r_wrap_pulse <= 1'b0;
        end
    end

    assign led_out    = r_led;
    assign step_pulse = r_step_pulse;
    assign wrap_pulse = r_wrap_pulse;

endmodule : led_pattern_sequencer
`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_led_pattern_sequencer                                    |
// | Brief  : Self-checking bench: vector table, directed corner cases    |
// |          and randomized traffic against a step-index pattern model.  |
// | Rev    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------+
module tb_led_pattern_sequencer;

    localparam int W  = 8;
    localparam int PW = 16;

    logic          clk;
    logic          rst_n;
    logic          enable;
    logic [1:0]    mode;
    logic [PW-1:0] period;
    logic          restart;
    logic [W-1:0]  led_out;
    logic          step_pulse;
    logic          wrap_pulse;

    int n_checks;
    int n_fail;

    // Reference model state: latched mode, steps since seed, tick count
    int m_mode;
    int m_k;
    int m_cnt;
    logic [W-1:0] m_led;
    logic         m_step;
    logic         m_wrap;

    typedef struct {
        logic       en;
        logic [1:0] md;
        int         per;
        logic       rs;
        logic [7:0] e_led;
        logic       e_step;
        logic       e_wrap;
    } vec_t;

    vec_t vecs[14];

    led_pattern_sequencer #(
        .WIDTH    (W),
        .PERIOD_W (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode       (mode),
        .period     (period),
        .restart    (restart),
        .led_out    (led_out),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pattern after k steps from the seed, computed from the mode's cycle
    function automatic logic [W-1:0] pattern(input int m, input int k);
        int p;
        int pos;
        case (m)
            0: begin
                p = k % W;
                return W'(1 << p);
            end
            1: begin
                p = k % W;
                return (p == 0) ? W'(1) : W'(1 << (W - p));
            end
            2: begin
                p   = k % (2 * (W - 1));
                pos = (p <= W - 1) ? p : 2 * (W - 1) - p;
                return W'(1 << pos);
            end
            default: begin
                p = k % (W + 1);
                return (p == W) ? W'(0) : W'((1 << (p + 1)) - 1);
            end
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_k    = 0;
        m_cnt  = 0;
        m_led  = pattern(0, 0);
        m_step = 1'b0;
        m_wrap = 1'b0;
    endtask

    task automatic model_update();
        int eff;
        m_step = 1'b0;
        m_wrap = 1'b0;
        if (restart || (int'(mode) != m_mode)) begin
            m_mode = int'(mode);
            m_k    = 0;
            m_cnt  = 0;
        end else if (enable) begin
            eff = (period == 0) ? 1 : int'(period);
            if (m_cnt >= eff - 1) begin
                m_cnt  = 0;
                m_k    = m_k + 1;
                m_step = 1'b1;
                m_wrap = (pattern(m_mode, m_k) == W'(1));
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        m_led = pattern(m_mode, m_k);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] el,
                         input logic es, input logic ew);
        n_checks++;
        if (led_out !== el || step_pulse !== es || wrap_pulse !== ew) begin
            n_fail++;
            $display("FAIL %s: got led=%02h step=%0b wrap=%0b, expected led=%02h step=%0b wrap=%0b",
                     name, led_out, step_pulse, wrap_pulse, el, es, ew);
        end
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        mode    = 2'd0;
        period  = PW'(1);
        restart = 1'b0;
        rst_n   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", W'(1), 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // en, mode, period, restart -> led, step, wrap (applied back to back)
        vecs[0]  = '{1'b1, 2'd0, 1, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 2'd0, 1, 1'b0, 8'h04, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1, 1'b0, 8'h04, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'd1, 1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 2'd1, 1, 1'b0, 8'h80, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 2'd1, 1, 1'b0, 8'h40, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 2'd1, 1, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 2'd2, 1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 2'd2, 1, 1'b0, 8'h02, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 2'd3, 1, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 2'd3, 1, 1'b0, 8'h03, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 2'd3, 0, 1'b0, 8'h07, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 2'd3, 2, 1'b0, 8'h07, 1'b0, 1'b0};
        vecs[13] = '{1'b1, 2'd3, 2, 1'b0, 8'h0F, 1'b1, 1'b0};

        do_reset();

        // Vector table
        for (int i = 0; i < 14; i++) begin
            enable  = vecs[i].en;
            mode    = vecs[i].md;
            period  = PW'(vecs[i].per);
            restart = vecs[i].rs;
            tick();
            check($sformatf("vec[%0d]", i), vecs[i].e_led, vecs[i].e_step, vecs[i].e_wrap);
        end

        // ROT_L at period 4: steps on every 4th enabled clock, wrap on the 8th step
        do_reset();
        enable = 1'b1;
        mode   = 2'd0;
        period = PW'(4);
        for (int i = 1; i <= 32; i++) begin
            tick();
            check($sformatf("rotl_p4[%0d]", i), W'(1 << ((i / 4) % W)),
                  (i % 4) == 0, i == 32);
        end

        // Count to 5 at period 8, pause, then shrink the period
        period = PW'(8);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("count_p8[%0d]", i), W'(1), 1'b0, 1'b0);
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("paused[%0d]", i), W'(1), 1'b0, 1'b0);
        end
        period = PW'(2);
        enable = 1'b1;
        tick();
        check("shrink_period_step", W'(2), 1'b1, 1'b0);

        // Mode change and restart on a cycle where a step is due
        period = PW'(1);
        tick();
        check("pre_reload_step", W'(4), 1'b1, 1'b0);
        mode = 2'd1;
        tick();
        check("mode_change_on_step", W'(1), 1'b0, 1'b0);
        tick();
        check("first_rotr_step", 8'h80, 1'b1, 1'b0);
        restart = 1'b1;
        tick();
        check("restart_on_step", W'(1), 1'b0, 1'b0);
        restart = 1'b0;
        tick();
        check("after_restart_step", 8'h80, 1'b1, 1'b0);
        tick();

        // Asynchronous reset between clock edges
        rst_n = 1'b0;
        model_reset();
        #2;
        check("async_reset", W'(1), 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;

        // Randomized traffic against the model
        mode    = 2'd0;
        restart = 1'b0;
        period  = PW'(2);
        enable  = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            tick();
            check($sformatf("rand[%0d]", i), m_led, m_step, m_wrap);
            enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            restart = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 29) == 0) period = PW'($urandom_range(0, 5));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_led_pattern_sequencer
`default_nettype wire

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Parametrised, multi-mode LED pattern engine; the next-generation chaser for the board LED bank. It advances a WIDTH-bit pattern once per programmable step period while enabled. Four modes are supported: rotate-left, rotate-right, bounce (ping-pong) and bar-fill. It emits per-step and end-of-sequence pulses for system sync and sits directly between the LED pins and the control/register block.

Parameters:
WIDTH, 8, number of LEDs; legal range is WIDTH >= 2.
PERIOD_W, 16, width of the runtime step-period input.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
enable  in  1  1 = advance pattern, 0 = freeze tick counter and pattern
mode  in  2  0 ROT_L, 1 ROT_R, 2 BOUNCE, 3 FILL
period  in  PERIOD_W  clocks per step; 0 is treated as 1
restart  in  1  synchronous reload of the seed for the current mode
led_out  out  WIDTH  LED drive (registered)
step_pulse  out  1  one-cycle pulse on every pattern advance
wrap_pulse  out  1  one-cycle pulse when the sequence returns to the seed

Behaviour:
- Reset (async, rst_n=0) values: led_out=1 (bit0 only), tick_cnt=0, mode_q=ROT_L, dir=UP, step_pulse=0, wrap_pulse=0.
- Seed is 1 (bit0 high) in every mode; dir resets to UP on every reload.
- Reload condition: restart=1 OR mode != mode_q, sampled on a clk edge. Effect on the next edge:
  - mode_q<=mode, led_out<=seed, tick_cnt<=0, dir<=UP.
  - Both pulses are 0 that cycle.
  - Reload applies regardless of enable and has priority over a step in the same cycle.
- Tick counter:
  - eff_period = max(period,1).
  - While enable=1: if tick_cnt >= eff_period-1, a step occurs and tick_cnt<=0; otherwise tick_cnt increments.
  - The ">=" compare means that shrinking period mid-count causes a step on the next enabled cycle.
  - period=1 gives one step per enabled clock. The first step after reset or reload lands on the eff_period-th enabled clock.
- enable=0: tick_cnt, led_out and dir hold; both pulses are 0.
- Step rules (registered; led_out updates on the same edge that step_pulse is asserted):
  - ROT_L: led <= {led[W-2:0], led[W-1]}.
  - ROT_R: led <= {led[0], led[W-1:1]}. First step from the seed gives the MSB.
  - BOUNCE: single hot bit moving by dir.
    - UP shifts left; when the result is the MSB, dir<=DOWN.
    - DOWN shifts right; when the result is bit0, dir<=UP.
    - No bit is repeated at the ends. Full cycle is 2*(WIDTH-1) steps.
  - FILL: led <= {led[W-2:0],1'b1} until all ones; the next step gives 0; the step after gives 1. Cycle is WIDTH+1 steps.
- wrap_pulse=1 exactly on a step whose new led_out equals the seed (1).
  - ROT_L and ROT_R: every WIDTH steps.
  - BOUNCE: every 2*(WIDTH-1) steps.
  - FILL: every WIDTH+1 steps.
- Pulse timing: step_pulse and wrap_pulse are registered, coincide with the updated led_out, and are never asserted on consecutive cycles unless eff_period=1.
- A non-one-hot led_out cannot occur in ROT or BOUNCE modes, since every entry to those modes passes through a reload.
- Reset mid-sequence: all state returns to the reset values immediately and asynchronously; deassertion is synchronised upstream.

Decomposition:
- Package led_seq_pkg holds:
  - Mode constants MODE_ROT_L=2'd0, MODE_ROT_R=2'd1, MODE_BOUNCE=2'd2, MODE_FILL=2'd3.
  - Direction constants DIR_UP=1'b0, DIR_DOWN=1'b1.
- Sub-module led_step_timer(clk, rst_n, enable, clear, period) -> step. It is the prescaler with the max(period,1) and ">=" rules. The pattern datapath and mode/dir register stay in the top module.

Test Plan:
- Reset then WIDTH=8, mode=0, period=4, enable=1 -> led 01,02,04,...,80,01. Steps land on enabled clocks 4,8,... wrap_pulse coincides with the return to 01 on step 8.
- mode=1, period=1 -> led 80,40,...,01 on consecutive clocks. wrap_pulse on the 8th step. step_pulse held high continuously.
- mode=2, period=1 -> 02,04,...,80,40,...,01. No repeat of 80 or 01 at the ends. wrap_pulse every 14 steps.
- mode=3, period=2 -> 01,03,07,0F,1F,3F,7F,FF,00,01. wrap_pulse on the step to 01, every 9 steps.
- Drop enable for 10 clocks mid-count, then change period 8->2 while tick_cnt=5 -> led_out and pulses frozen during the pause; a step occurs on the first enabled clock after the change.
- Change mode (or assert restart) in the same cycle a step is due -> led_out=01, no pulses, tick_cnt=0. Async rst_n low mid-sequence -> led_out=01 immediately.
